// File: rtl/event_arbiter.sv
// Round-robin arbiter for 4 device on/off event requesters feeding an active-device monitor.
// Each event takes two cycles: ARB picks a winner, ISSUE acknowledges it and updates count.
module event_arbiter #(
  parameter logic [7:0] MAX_DEV = 8'd200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] req_on,
  output logic [3:0] ack,
  output logic [3:0] reject,
  output logic       change,
  output logic       on_off,
  output logic [7:0] count,
  output logic       busy
);

  typedef enum logic {ARB, ISSUE} state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] winner;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       pick_on;
  logic       refuse;

  // First requesting index at or above rr_ptr, wrapping 3->0.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign pick_on = req_on[pick];
  assign refuse  = pick_on ? (count == MAX_DEV) : (count == 8'd0);

  // Outputs are registered on the ARB->ISSUE edge so they are valid throughout ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB;
      rr_ptr <= 2'd0;
      winner <= 2'd0;
      count  <= 8'd0;
      ack    <= 4'b0000;
      reject <= 4'b0000;
      change <= 1'b0;
      on_off <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (found) begin
            state  <= ISSUE;
            winner <= pick;
            busy   <= 1'b1;
            ack    <= 4'b0001 << pick;
            if (refuse) begin
              reject <= 4'b0001 << pick;
              change <= 1'b0;
              on_off <= 1'b0;
            end else begin
              reject <= 4'b0000;
              change <= 1'b1;
              on_off <= pick_on;
            end
          end else begin
            ack    <= 4'b0000;
            reject <= 4'b0000;
            change <= 1'b0;
            on_off <= 1'b0;
            busy   <= 1'b0;
          end
        end
        ISSUE: begin
          state  <= ARB;
          rr_ptr <= winner + 2'd1;
          busy   <= 1'b0;
          ack    <= 4'b0000;
          reject <= 4'b0000;
          change <= 1'b0;
          on_off <= 1'b0;
          if (change) begin
            count <= on_off ? count + 8'd1 : count - 8'd1;
          end
        end
        default: begin
          state <= ARB;
        end
      endcase
    end
  end

endmodule
